// File: rtl/des_key_schedule_seq.sv
// Sequential DES key schedule: streams one rotated C||D word per round over valid/ready,
// in encrypt or decrypt order, from a single shared pair of half-rotators.
module des_half_rot #(
    parameter int HALF_W = 28,
    parameter int AMT_W  = 5
) (
    input  logic [HALF_W-1:0] x,
    input  logic [AMT_W-1:0]  amt,
    output logic [HALF_W-1:0] y
);
    logic [2*HALF_W-1:0] dbl;

    // Upper half of {x,x} << amt is x rotated left by amt (amt < HALF_W).
    assign dbl = {x, x} << amt;
    assign y   = dbl[2*HALF_W-1:HALF_W];
endmodule

module des_key_schedule_seq #(
    parameter int                HALF_W    = 28,
    parameter int                ROUNDS    = 16,
    parameter logic [ROUNDS-1:0] SHIFT_MAP = 16'h8103,
    parameter int                RIDX_W    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  decrypt,
    input  logic [2*HALF_W-1:0]   key_in,
    output logic                  busy,
    output logic                  rk_valid,
    input  logic                  rk_ready,
    output logic [2*HALF_W-1:0]   rk_data,
    output logic [RIDX_W-1:0]     rk_round,
    output logic                  done
);
    localparam int AMT_W = $clog2(HALF_W);

    function automatic int total_shift();
        int t;
        t = 0;
        for (int i = 0; i < ROUNDS; i++) t += SHIFT_MAP[i] ? 1 : 2;
        return t % HALF_W;
    endfunction

    localparam logic [AMT_W-1:0] TOTAL_AMT = AMT_W'(total_shift());
    localparam logic [AMT_W-1:0] FIRST_AMT = SHIFT_MAP[0] ? AMT_W'(1) : AMT_W'(2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state, state_nxt;
    logic                       dec_q, dec_nxt;
    logic [2*HALF_W-1:0]        data_nxt;
    logic [RIDX_W-1:0]          round_nxt, step_idx;
    logic                       step_one;
    logic [AMT_W-1:0]           step_amt, rot_amt;
    logic [1:0][HALF_W-1:0]     rot_in, rot_out;

    // C and D rotate independently; index 1 is C, index 0 is D.
    for (genvar g = 0; g < 2; g++) begin : g_half
        des_half_rot #(.HALF_W(HALF_W), .AMT_W(AMT_W)) u_rot (
            .x   (rot_in[g]),
            .amt (rot_amt),
            .y   (rot_out[g])
        );
    end

    always_comb begin
        // Encrypt moves to round r+1 using bit r; decrypt undoes round ROUNDS-r+1 (bit ROUNDS-r).
        step_idx = dec_q ? (RIDX_W'(ROUNDS) - rk_round) : rk_round;
        step_one = 1'b0;
        for (int i = 0; i < ROUNDS; i++)
            if (step_idx == RIDX_W'(i)) step_one = SHIFT_MAP[i];
        step_amt = step_one ? AMT_W'(1) : AMT_W'(2);
    end

    always_comb begin
        state_nxt = state;
        dec_nxt   = dec_q;
        data_nxt  = rk_data;
        round_nxt = rk_round;
        rot_in    = rk_data;
        // A right rotate by n is a left rotate by HALF_W-n.
        rot_amt   = dec_q ? (AMT_W'(HALF_W) - step_amt) : step_amt;
        case (state)
            IDLE: begin
                rot_in  = key_in;
                rot_amt = decrypt ? TOTAL_AMT : FIRST_AMT;
                if (start) begin
                    state_nxt = RUN;
                    dec_nxt   = decrypt;
                    data_nxt  = rot_out;
                    round_nxt = RIDX_W'(1);
                end
            end
            RUN: begin
                if (rk_ready) begin
                    if (rk_round == RIDX_W'(ROUNDS)) begin
                        state_nxt = DONE;
                    end else begin
                        data_nxt  = rot_out;
                        round_nxt = rk_round + RIDX_W'(1);
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dec_q    <= 1'b0;
            rk_data  <= '0;
            rk_round <= '0;
        end else begin
            state    <= state_nxt;
            dec_q    <= dec_nxt;
            rk_data  <= data_nxt;
            rk_round <= round_nxt;
        end
    end

    assign busy     = (state == RUN);
    assign rk_valid = (state == RUN);
    assign done     = (state == DONE);
endmodule

// File: tb/tb_des_key_schedule_seq.sv
// Scoreboard bench for des_key_schedule_seq: DES-sized instance plus a small override instance.
module tb_des_key_schedule_seq;
    localparam logic [15:0] MAP = 16'h8103;
    localparam logic [55:0] KEY = 56'hABCDEF12345678;

    typedef struct {
        logic [55:0] data;
        logic [4:0]  rnd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, decrypt, rk_ready;
    logic [55:0] key_in, rk_data;
    logic        busy, rk_valid, done;
    logic [4:0]  rk_round;

    logic        s_start, s_dec, s_busy, s_valid, s_done;
    logic [15:0] s_key, s_data;
    logic [2:0]  s_round;

    int   n_chk = 0;
    int   n_err = 0;
    int   rdy_mode = 0;
    int   stall_cnt = 0;
    bit   done_exp = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    des_key_schedule_seq u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .key_in(key_in),
        .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
        .rk_round(rk_round), .done(done)
    );

    des_key_schedule_seq #(.HALF_W(8), .ROUNDS(4), .SHIFT_MAP(4'b0101), .RIDX_W(3)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .decrypt(s_dec), .key_in(s_key),
        .busy(s_busy), .rk_valid(s_valid), .rk_ready(1'b1), .rk_data(s_data),
        .rk_round(s_round), .done(s_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Round k is the key rotated by the cumulative shift of rounds 1..k; decrypt k = encrypt 17-k.
    function automatic logic [55:0] model_rk(input logic [55:0] key, input bit dec, input int k);
        int kk, n;
        logic [27:0] c, d;
        kk = dec ? 17 - k : k;
        n  = 0;
        for (int j = 0; j < kk; j++) n += (((MAP >> j) & 16'd1) != 16'd0) ? 1 : 2;
        c = key[55:28];
        d = key[27:0];
        for (int i = 0; i < n % 28; i++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        return {c, d};
    endfunction

    // Ready driver: always high, or random with a 5-cycle stall at round 8.
    initial begin
        rk_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0) begin
                rk_ready  = 1'b1;
                stall_cnt = 0;
            end else if (rk_valid && rk_round == 5'd8 && stall_cnt < 5) begin
                rk_ready = 1'b0;
                stall_cnt++;
            end else begin
                rk_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: every valid cycle must show the scoreboard head; pop on acceptance.
    initial begin
        exp_t e;
        bit   nxt;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_exp = 0;
                continue;
            end
            chk("done", 64'(done), 64'(done_exp));
            nxt = 0;
            if (rk_valid) begin
                if (sb.size() == 0) begin
                    chk("extra_key", 64'(rk_round), 64'd0);
                end else begin
                    e = sb[0];
                    chk("rk_data", 64'(rk_data), 64'(e.data));
                    chk("rk_round", 64'(rk_round), 64'(e.rnd));
                    if (rk_ready) begin
                        void'(sb.pop_front());
                        nxt = (e.rnd == 5'd16);
                    end
                end
            end
            done_exp = nxt;
        end
    end

    task automatic start_sched(input logic [55:0] key, input bit dec);
        exp_t e;
        @(posedge clk); #1;
        start   = 1'b1;
        key_in  = key;
        decrypt = dec;
        for (int k = 1; k <= 16; k++) begin
            e.data = model_rk(key, dec, k);
            e.rnd  = 5'(k);
            sb.push_back(e);
        end
    endtask

    task automatic finish_sched(input bit spur);
        bit got_done;
        @(posedge clk); #1;
        start   = 1'b0;
        key_in  = ~key_in;
        decrypt = ~decrypt;
        chk("first_valid", 64'(rk_valid), 64'd1);
        chk("first_busy", 64'(busy), 64'd1);
        got_done = 0;
        for (int c = 0; c < 300 && !got_done; c++) begin
            @(posedge clk); #1;
            start  = spur && rk_valid && (rk_round == 5'd3 || rk_round == 5'd16);
            key_in = 56'h0123456789ABCD;
            if (done) begin
                got_done = 1;
                start    = spur;
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
        if (!got_done) chk("done_timeout", 64'd0, 64'd1);
        chk("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic small_run(input bit dec);
        logic [15:0] tbl [4];
        exp_t        sq[$];
        exp_t        e;
        tbl = '{16'h0302, 16'h0C08, 16'h1810, 16'h6040};
        @(posedge clk); #1;
        s_start = 1'b1;
        s_key   = 16'h8101;
        s_dec   = dec;
        for (int r = 1; r <= 4; r++) begin
            e.data = 56'(dec ? tbl[4 - r] : tbl[r - 1]);
            e.rnd  = 5'(r);
            sq.push_back(e);
        end
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int c = 0; c < 20 && sq.size() > 0; c++) begin
            e = sq.pop_front();
            chk("s_valid", 64'(s_valid), 64'd1);
            chk("s_data", 64'(s_data), 64'(e.data));
            chk("s_round", 64'(s_round), 64'(e.rnd));
            @(posedge clk); #1;
        end
        chk("s_done", 64'(s_done), 64'd1);
        chk("s_valid_end", 64'(s_valid), 64'd0);
        @(posedge clk); #1;
        chk("s_done_clr", 64'(s_done), 64'd0);
    endtask

    initial begin
        bit hit;
        rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; key_in = '0;
        s_start = 1'b0; s_dec = 1'b0; s_key = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(rk_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_data", 64'(rk_data), 64'd0);
        chk("rst_round", 64'(rk_round), 64'd0);
        chk("rst_s_data", 64'(s_data), 64'd0);
        rst_n = 1'b1;

        // Encrypt, ready always high, with spec reference words pinned.
        start_sched(KEY, 1'b0);
        sb[0].data  = 56'h579BDE3468ACF0;
        sb[1].data  = 56'hAF37BC68D159E0;
        sb[15].data = 56'hABCDEF12345678;
        finish_sched(1'b0);

        // Decrypt on the same key.
        start_sched(KEY, 1'b1);
        sb[0].data = 56'hABCDEF12345678;
        sb[1].data = 56'hD5E6F7811A2B3C;
        finish_sched(1'b0);

        // Backpressure, both directions.
        rdy_mode = 1;
        start_sched(56'h13579BDF02468A, 1'b0);
        finish_sched(1'b0);
        start_sched(56'hF0E1D2C3B4A596, 1'b1);
        finish_sched(1'b0);
        rdy_mode = 0;

        // Spurious starts at rounds 3, 16 and in the done cycle, then back-to-back start.
        start_sched(KEY, 1'b0);
        finish_sched(1'b1);
        start_sched(56'h0F1E2D3C4B5A69, 1'b1);
        finish_sched(1'b0);

        // Asynchronous abort at round 6.
        start_sched(KEY, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        hit = 0;
        for (int c = 0; c < 50 && !hit; c++) begin
            if (rk_valid && rk_round == 5'd6) hit = 1;
            else begin @(posedge clk); #1; end
        end
        if (!hit) chk("r6_timeout", 64'd0, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 64'(rk_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_data", 64'(rk_data), 64'd0);
        chk("abort_round", 64'(rk_round), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        start_sched(KEY, 1'b0);
        finish_sched(1'b0);

        // Small override instance.
        small_run(1'b0);
        small_run(1'b1);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
